// File: rtl/alu_ctrl_gen.sv
// rtl/alu_ctrl_gen.sv - MIPS instruction to ALU control decoder with 2-entry skid buffer
module alu_ctrl_gen #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Flush,
    input  logic             In_Valid,
    output logic             In_Ready,
    input  logic [31:0]      Instruction,
    output logic             Out_Valid,
    input  logic             Out_Ready,
    output logic [3:0]       ALUctrl,
    output logic [4:0]       Inst_10_6,
    output logic             Alu_Src,
    output logic [31:0]      Imm_Ext,
    output logic             Illegal,
    output logic [CNT_W-1:0] Illegal_Count
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_XOR = 4'b0011;
    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_SRL = 4'b1000;
    localparam logic [3:0] OP_SRA = 4'b1001;
    localparam logic [3:0] OP_LUI = 4'b1010;
    localparam logic [3:0] OP_NOR = 4'b1100;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    typedef struct packed {
        logic        illegal;
        logic        alu_src;
        logic [3:0]  op;
        logic [4:0]  shamt;
        logic [31:0] imm;
    } entry_t;

    localparam entry_t RST_ENTRY = '{illegal: 1'b0, alu_src: 1'b0, op: OP_ADD,
                                     shamt: 5'd0, imm: 32'd0};

    logic [1:0] state;
    entry_t     head;
    entry_t     skid;
    entry_t     dec;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic [31:0] sext;
    logic [31:0] zext;
    logic       accept;
    logic       deliver;
    logic       unused_fields;

    assign opcode        = Instruction[31:26];
    assign funct         = Instruction[5:0];
    assign sext          = {{16{Instruction[15]}}, Instruction[15:0]};
    assign zext          = {16'd0, Instruction[15:0]};
    assign unused_fields = ^Instruction[25:16];

    // Unsupported encodings fall through with ADD and register operand B.
    always_comb begin
        dec.illegal = 1'b0;
        dec.alu_src = 1'b0;
        dec.op      = OP_ADD;
        dec.shamt   = Instruction[10:6];
        dec.imm     = sext;
        case (opcode)
            6'h00: begin
                case (funct)
                    6'h20, 6'h21: dec.op = OP_ADD;
                    6'h22, 6'h23: dec.op = OP_SUB;
                    6'h24:        dec.op = OP_AND;
                    6'h25:        dec.op = OP_OR;
                    6'h26:        dec.op = OP_XOR;
                    6'h27:        dec.op = OP_NOR;
                    6'h2A:        dec.op = OP_SLT;
                    6'h00:        dec.op = OP_SLL;
                    6'h02:        dec.op = OP_SRL;
                    6'h03:        dec.op = OP_SRA;
                    default:      dec.illegal = 1'b1;
                endcase
            end
            6'h08, 6'h09, 6'h23, 6'h2B: dec.alu_src = 1'b1;
            6'h0A: begin
                dec.alu_src = 1'b1;
                dec.op      = OP_SLT;
            end
            6'h0C: begin
                dec.alu_src = 1'b1;
                dec.op      = OP_AND;
                dec.imm     = zext;
            end
            6'h0D: begin
                dec.alu_src = 1'b1;
                dec.op      = OP_OR;
                dec.imm     = zext;
            end
            6'h0E: begin
                dec.alu_src = 1'b1;
                dec.op      = OP_XOR;
                dec.imm     = zext;
            end
            6'h0F: begin
                dec.alu_src = 1'b1;
                dec.op      = OP_LUI;
                dec.imm     = zext;
            end
            6'h04, 6'h05: dec.op = OP_SUB;
            default:      dec.illegal = 1'b1;
        endcase
    end

    assign In_Ready  = (state != ST_FULL);
    assign Out_Valid = (state != ST_EMPTY);
    assign accept    = In_Valid && In_Ready;
    assign deliver   = Out_Valid && Out_Ready;

    assign ALUctrl   = head.op;
    assign Inst_10_6 = head.shamt;
    assign Alu_Src   = head.alu_src;
    assign Imm_Ext   = head.imm;
    assign Illegal   = head.illegal;

    // head drives the outputs directly; skid only fills when the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_EMPTY;
            head  <= RST_ENTRY;
            skid  <= '0;
        end else if (Flush) begin
            state <= ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        head  <= dec;
                        state <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && deliver) begin
                        head <= dec;
                    end else if (accept) begin
                        skid  <= dec;
                        state <= ST_FULL;
                    end else if (deliver) begin
                        state <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (deliver) begin
                        head  <= skid;
                        state <= ST_ONE;
                    end
                end
                default: state <= ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Illegal_Count <= '0;
        end else if (deliver && !Flush && head.illegal && !(&Illegal_Count)) begin
            Illegal_Count <= Illegal_Count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_alu_ctrl_gen.sv
// tb/tb_alu_ctrl_gen.sv - randomized and directed bench for alu_ctrl_gen against a queue model
module tb_alu_ctrl_gen;

    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             Flush;
    logic             In_Valid;
    logic             In_Ready;
    logic [31:0]      Instruction;
    logic             Out_Valid;
    logic             Out_Ready;
    logic [3:0]       ALUctrl;
    logic [4:0]       Inst_10_6;
    logic             Alu_Src;
    logic [31:0]      Imm_Ext;
    logic             Illegal;
    logic [CNT_W-1:0] Illegal_Count;

    always #5 clk = ~clk;

    alu_ctrl_gen #(.CNT_W(CNT_W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .Flush(Flush),
        .In_Valid(In_Valid),
        .In_Ready(In_Ready),
        .Instruction(Instruction),
        .Out_Valid(Out_Valid),
        .Out_Ready(Out_Ready),
        .ALUctrl(ALUctrl),
        .Inst_10_6(Inst_10_6),
        .Alu_Src(Alu_Src),
        .Imm_Ext(Imm_Ext),
        .Illegal(Illegal),
        .Illegal_Count(Illegal_Count)
    );

    typedef struct packed {
        logic        ill;
        logic        src;
        logic [3:0]  op;
        logic [4:0]  sh;
        logic [31:0] imm;
    } exp_t;

    exp_t q[$];
    int   mcnt  = 0;
    int   total = 0;
    int   bad   = 0;

    function automatic exp_t model_dec(input logic [31:0] w);
        exp_t        e;
        logic [5:0]  opc;
        logic [5:0]  fn;
        logic [31:0] se;
        logic [31:0] ze;
        opc   = w[31:26];
        fn    = w[5:0];
        se    = {{16{w[15]}}, w[15:0]};
        ze    = {16'd0, w[15:0]};
        e.sh  = w[10:6];
        e.ill = 1'b0;
        e.src = 1'b0;
        e.imm = se;
        e.op  = 4'b0010;
        if (opc == 6'h00) begin
            if (fn == 6'h20 || fn == 6'h21)      e.op = 4'b0010;
            else if (fn == 6'h22 || fn == 6'h23) e.op = 4'b0110;
            else if (fn == 6'h24)                e.op = 4'b0000;
            else if (fn == 6'h25)                e.op = 4'b0001;
            else if (fn == 6'h26)                e.op = 4'b0011;
            else if (fn == 6'h27)                e.op = 4'b1100;
            else if (fn == 6'h2A)                e.op = 4'b0111;
            else if (fn == 6'h00)                e.op = 4'b0100;
            else if (fn == 6'h02)                e.op = 4'b1000;
            else if (fn == 6'h03)                e.op = 4'b1001;
            else                                 e.ill = 1'b1;
        end else if (opc == 6'h08 || opc == 6'h09 || opc == 6'h23 || opc == 6'h2B) begin
            e.src = 1'b1;
        end else if (opc == 6'h0A) begin
            e.src = 1'b1; e.op = 4'b0111;
        end else if (opc == 6'h0C) begin
            e.src = 1'b1; e.op = 4'b0000; e.imm = ze;
        end else if (opc == 6'h0D) begin
            e.src = 1'b1; e.op = 4'b0001; e.imm = ze;
        end else if (opc == 6'h0E) begin
            e.src = 1'b1; e.op = 4'b0011; e.imm = ze;
        end else if (opc == 6'h0F) begin
            e.src = 1'b1; e.op = 4'b1010; e.imm = ze;
        end else if (opc == 6'h04 || opc == 6'h05) begin
            e.op = 4'b0110;
        end else begin
            e.ill = 1'b1;
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [63:0] dut_entry();
        exp_t e;
        e.ill = Illegal;
        e.src = Alu_Src;
        e.op  = ALUctrl;
        e.sh  = Inst_10_6;
        e.imm = Imm_Ext;
        return 64'(e);
    endfunction

    // One cycle: compare DUT to model at the falling edge, then drive and advance the model.
    task automatic step(input logic v, input logic [31:0] ins, input logic r, input logic f);
        logic acc;
        logic del;
        @(negedge clk);
        chk("out_valid", 64'(Out_Valid), 64'(q.size() != 0));
        chk("in_ready", 64'(In_Ready), 64'(q.size() != 2));
        chk("illegal_count", 64'(Illegal_Count), 64'(mcnt));
        if (q.size() != 0) chk("entry", dut_entry(), 64'(q[0]));
        In_Valid    = v;
        Instruction = ins;
        Out_Ready   = r;
        Flush       = f;
        acc = v && (q.size() < 2);
        del = (q.size() != 0) && r;
        if (f) begin
            q.delete();
        end else begin
            if (del) begin
                if (q[0].ill && mcnt < CNT_MAX) mcnt++;
                void'(q.pop_front());
            end
            if (acc) q.push_back(model_dec(ins));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_out_valid"}, 64'(Out_Valid), 64'd0);
        chk({tag, "_in_ready"}, 64'(In_Ready), 64'd1);
        chk({tag, "_count"}, 64'(Illegal_Count), 64'd0);
        chk({tag, "_fields"}, dut_entry(), 64'({1'b0, 1'b0, 4'b0010, 5'd0, 32'd0}));
    endtask

    // Called at a falling edge; asserts reset between clock edges.
    task automatic do_async_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs(tag);
        q.delete();
        mcnt      = 0;
        In_Valid  = 1'b0;
        Flush     = 1'b0;
        Out_Ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0]  ops [12];
        logic [31:0] w;
        ops = '{6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h0B};
        w = $urandom;
        case ($urandom_range(0, 3))
            0: w[31:26] = 6'h00;
            1: w[31:26] = ops[$urandom_range(0, 11)];
            2: ;
            default: w = 32'h0;
        endcase
        return w;
    endfunction

    initial begin
        rst_n       = 1'b0;
        Flush       = 1'b0;
        In_Valid    = 1'b0;
        Out_Ready   = 1'b0;
        Instruction = 32'h0;

        chk("model_addi", 64'(model_dec(32'h2008FFFF)), 64'({1'b0, 1'b1, 4'b0010, 5'd31, 32'hFFFFFFFF}));
        chk("model_mult", 64'(model_dec(32'h00000018)), 64'({1'b1, 1'b0, 4'b0010, 5'd0, 32'h00000018}));
        chk("model_ori", 64'(model_dec(32'h3508F000)), 64'({1'b0, 1'b1, 4'b0001, 5'd0, 32'h0000F000}));
        chk("model_beq", 64'(model_dec(32'h10000001)), 64'({1'b0, 1'b0, 4'b0110, 5'd0, 32'h00000001}));

        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Single addi with the consumer ready.
        step(1'b1, 32'h2008FFFF, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("addi_valid", 64'(Out_Valid), 64'd1);
        chk("addi_op", 64'(ALUctrl), 64'(4'b0010));
        chk("addi_src", 64'(Alu_Src), 64'd1);
        chk("addi_imm", 64'(Imm_Ext), 64'hFFFFFFFF);
        chk("addi_ill", 64'(Illegal), 64'd0);

        // Back-to-back stream at full throughput.
        step(1'b1, 32'h00094080, 1'b1, 1'b0);
        step(1'b1, 32'h00094083, 1'b1, 1'b0);
        chk("sll_op", 64'(ALUctrl), 64'(4'b0100));
        chk("sll_sh", 64'(Inst_10_6), 64'd2);
        chk("stream_rdy0", 64'(In_Ready), 64'd1);
        step(1'b1, 32'h3C011234, 1'b1, 1'b0);
        chk("sra_op", 64'(ALUctrl), 64'(4'b1001));
        chk("sra_sh", 64'(Inst_10_6), 64'd2);
        chk("stream_rdy1", 64'(In_Ready), 64'd1);
        step(1'b1, 32'h3508F000, 1'b1, 1'b0);
        chk("lui_op", 64'(ALUctrl), 64'(4'b1010));
        chk("lui_imm", 64'(Imm_Ext), 64'h00001234);
        chk("stream_rdy2", 64'(In_Ready), 64'd1);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("ori_op", 64'(ALUctrl), 64'(4'b0001));
        chk("ori_imm", 64'(Imm_Ext), 64'h0000F000);
        step(1'b0, 32'h0, 1'b1, 1'b0);

        // Backpressure: two accepted, third held until space frees.
        step(1'b1, 32'h01094020, 1'b0, 1'b0);
        step(1'b1, 32'h01094024, 1'b0, 1'b0);
        step(1'b1, 32'h1109FFFE, 1'b0, 1'b0);
        chk("bp_full_rdy", 64'(In_Ready), 64'd0);
        step(1'b1, 32'h1109FFFE, 1'b0, 1'b0);
        chk("bp_hold_valid", 64'(Out_Valid), 64'd1);
        chk("bp_hold_op", 64'(ALUctrl), 64'(4'b0010));
        step(1'b1, 32'h1109FFFE, 1'b1, 1'b0);
        step(1'b1, 32'h1109FFFE, 1'b1, 1'b0);
        repeat (4) step(1'b0, 32'h0, 1'b1, 1'b0);

        // Flush of a full buffer of illegal entries with same-cycle accept and deliver.
        step(1'b1, 32'h00000018, 1'b0, 1'b0);
        step(1'b1, 32'h0000000C, 1'b0, 1'b0);
        step(1'b1, 32'h01094020, 1'b1, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("flush_valid", 64'(Out_Valid), 64'd0);
        chk("flush_rdy", 64'(In_Ready), 64'd1);
        chk("flush_count", 64'(Illegal_Count), 64'd0);
        repeat (3) step(1'b0, 32'h0, 1'b1, 1'b0);

        // Saturating illegal counter.
        repeat (300) step(1'b1, 32'h00000018, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("mult_op", 64'(ALUctrl), 64'(4'b0010));
        chk("mult_ill", 64'(Illegal), 64'd1);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("sat_count", 64'(Illegal_Count), 64'd255);

        // Asynchronous reset while full, then a branch.
        step(1'b1, 32'h00000018, 1'b0, 1'b0);
        step(1'b1, 32'h2008FFFF, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        chk("pre_rst_full", 64'(In_Ready), 64'd0);
        do_async_reset("async_rst");
        step(1'b1, 32'h10000001, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("beq_valid", 64'(Out_Valid), 64'd1);
        chk("beq_op", 64'(ALUctrl), 64'(4'b0110));
        chk("beq_src", 64'(Alu_Src), 64'd0);
        chk("beq_imm", 64'(Imm_Ext), 64'h00000001);

        // Random traffic with occasional flushes and one mid-run reset.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 31) == 0);
            if (i == 1500) do_async_reset("rand_rst");
        end
        repeat (4) step(1'b0, 32'h0, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_ctrl_gen.md
Name: alu_ctrl_gen

Overview:
- Decode-side producer for the ALU operation interface: accepts 32-bit MIPS instructions and emits the 4-bit ALU operation code, shift amount, operand-B select and extended immediate the ALU datapath consumes.
- Sits between instruction fetch/decode and the ALU.
- Registered with a valid/ready handshake and a 2-entry skid buffer, so either side can stall without losing instructions.
- Also flags unsupported encodings and counts them.

Parameters:
- CNT_W, 8, width of the saturating illegal-instruction counter.

Ports:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- Flush  input  1  synchronous discard of all buffered entries.
- In_Valid  input  1  Instruction valid.
- In_Ready  output  1  buffer can accept.
- Instruction  input  32  raw instruction word.
- Out_Valid  output  1  decoded entry available.
- Out_Ready  input  1  consumer accepts.
- ALUctrl  output  4  operation code.
- Inst_10_6  output  5  shift amount, Instruction[10:6].
- Alu_Src  output  1  1 = operand B is Imm_Ext, 0 = register.
- Imm_Ext  output  32  extended Instruction[15:0].
- Illegal  output  1  entry is an unsupported encoding.
- Illegal_Count  output  CNT_W  saturating count of illegal entries delivered.

Behaviour:
- Op codes: AND 0000, OR 0001, ADD 0010, XOR 0011, SLL 0100, SUB 0110, SLT 0111, SRL 1000, SRA 1001, LUI 1010, NOR 1100. Codes 0101, 1011, 1101, 1110 and 1111 are never emitted.
- R-type (op 0x00), Alu_Src=0, funct map:
  - 0x20/0x21 ADD
  - 0x22/0x23 SUB
  - 0x24 AND
  - 0x25 OR
  - 0x26 XOR
  - 0x27 NOR
  - 0x2A SLT
  - 0x00 SLL
  - 0x02 SRL
  - 0x03 SRA
  - Instruction 0x00000000 decodes as SLL with shamt 0 (nop) and is legal.
- I-type, Alu_Src=1:
  - 0x08/0x09 ADD, sign-extended.
  - 0x0A SLT, sign-extended.
  - 0x0C AND, zero-extended.
  - 0x0D OR, zero-extended.
  - 0x0E XOR, zero-extended.
  - 0x0F LUI, zero-extended.
  - 0x23 lw / 0x2B sw ADD, sign-extended.
- Branches 0x04/0x05: SUB, Alu_Src=0, Imm_Ext sign-extended.
- Any other op/funct (including sllv/srlv/srav and mult/div): Illegal=1, ALUctrl=ADD, Alu_Src=0, Imm_Ext sign-extended.
- Inst_10_6 always carries Instruction[10:6], whatever the opcode.
- Decode is combinational on Instruction; the result is written into the buffer on accept (In_Valid && In_Ready).
- Buffer state: EMPTY (0 entries), ONE, FULL (2 entries). In_Ready = state != FULL, driven directly from registered state with no combinational path from Out_Ready.
- Transitions, per cycle:
  - accept only: +1 entry.
  - deliver only (Out_Valid && Out_Ready): −1 entry.
  - both: count unchanged.
  - FULL: no accept.
- Latency: an instruction accepted at edge N appears on outputs after edge N (Out_Valid=1 in cycle N+1) when the buffer was EMPTY, or when in ONE and the head is delivered the same cycle.
- Throughput is 1 per cycle when Out_Ready is held high.
- FIFO order is strictly preserved.
- While Out_Valid && !Out_Ready, all outputs hold stable.
- Flush: next state EMPTY; same-cycle accept and deliver are ignored, and a flushed entry does not bump Illegal_Count. Flush wins over every other event.
- Illegal_Count increments when an entry with Illegal=1 is delivered; it saturates at 2^CNT_W−1 and is cleared only by reset.
- Reset (any time, including mid-transfer) gives:
  - state EMPTY, Out_Valid=0, In_Ready=1;
  - ALUctrl=0010, Inst_10_6=0, Alu_Src=0, Imm_Ext=0, Illegal=0, Illegal_Count=0;
  - buffered contents discarded.
- Output fields are don't-care while Out_Valid=0; the bench checks them only when Out_Valid=1.

Test Plan:
- Push 0x2008FFFF (addi) with Out_Ready=1 → next cycle Out_Valid=1, ALUctrl=0010, Alu_Src=1, Imm_Ext=0xFFFFFFFF, Illegal=0.
- Stream 0x00094080 (sll shamt 2), 0x00094083 (sra), 0x3C011234 (lui), 0x3508F000 (ori) back-to-back → four consecutive outputs:
  - 0100/Inst_10_6=2
  - 1001/Inst_10_6=2
  - 1010/Imm_Ext=0x00001234
  - 0001/Imm_Ext=0x0000F000
  - In_Ready stays 1 throughout.
- Out_Ready=0, push 3 instructions → first two accepted, In_Ready=0 after second, third held. Then Out_Ready=1 → all three delivered in order with no loss or duplication.
- Push 0x00000018 (mult) 300 times with CNT_W=8 → each delivers Illegal=1, ALUctrl=0010. Illegal_Count ends at 255.
- FULL buffer, assert Flush with In_Valid=1 → next cycle Out_Valid=0, In_Ready=1, count unchanged, the flushed instruction never appears.
- Deassert rst_n asynchronously mid-stream while FULL → Out_Valid=0, In_Ready=1, Illegal_Count=0 immediately, without waiting for a clock edge. After release, 0x10000001 (beq) → ALUctrl=0110, Alu_Src=0, Imm_Ext=0x00000001.
